// File: rtl/if_fetch_if.sv
// ============================================================================
// Module   : if_fetch_if
// Brief    : Fetch-unit bus: control in, imem req/ack handshake, decode-side buffer out
// Revision : 1.0
// ============================================================================
`default_nettype none

interface if_fetch_if;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        valid;

    // Fetch unit side
    modport master (
        input  freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
        output imem_req, imem_addr, PC, instruction, valid
    );

    // Memory / pipeline environment side
    modport slave (
        output freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
        input  imem_req, imem_addr, PC, instruction, valid
    );
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction fetch with imem req/ack, 1-entry output buffer, branch squash
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  wire logic  clk,
    input  wire logic  rst,
    if_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_RUN    = 2'd1,
        S_SQUASH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_squash_addr;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic        r_buf_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_fill;
    logic        w_to_squash;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_addr      = r_pc;
        case (r_state)
            S_RESET: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // A full buffer may only be refilled on an edge where it drains
                w_req = ~r_buf_valid | ~bus.freeze;
                if (bus.branch_taken && w_req && !bus.imem_ack)
                    w_state_nxt = S_SQUASH;
            end
            S_SQUASH: begin
                w_req  = 1'b1;
                w_addr = r_squash_addr;
                if (bus.imem_ack)
                    w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_RESET;
            end
        endcase
    end

    assign w_fill      = (r_state == S_RUN) && w_req && bus.imem_ack && !bus.branch_taken;
    assign w_to_squash = (r_state == S_RUN) && (w_state_nxt == S_SQUASH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_squash_addr <= RESET_PC;
        end else begin
            if (bus.branch_taken)
                r_pc <= bus.branch_addr;
            else if (w_fill)
                r_pc <= r_pc + 32'd4;
            // Keep the abandoned address on the bus until memory acks it
            if (w_to_squash)
                r_squash_addr <= w_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_instr <= 32'd0;
            r_buf_pc    <= 32'd0;
        end else begin
            if (bus.branch_taken) begin
                r_buf_valid <= 1'b0;
            end else if (w_fill) begin
                r_buf_valid <= 1'b1;
                r_buf_instr <= bus.imem_rdata;
                r_buf_pc    <= r_pc + 32'd4;
            end else if (!bus.freeze) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    // Empty buffer presents a bubble (all-zero PC and instruction)
    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = w_addr;
    assign bus.valid       = r_buf_valid;
    assign bus.PC          = r_buf_valid ? r_buf_pc    : 32'd0;
    assign bus.instruction = r_buf_valid ? r_buf_instr : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Directed bench for if_fetch_unit with a variable-latency memory model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    int unsigned mem_lat;
    int unsigned r_wait_cnt;
    int          n_total;
    int          n_bad;

    if_fetch_if bus ();

    if_fetch_unit #(.RESET_PC(32'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acks once a request has been held for mem_lat cycles
    assign bus.imem_ack   = bus.imem_req && (r_wait_cnt >= mem_lat);
    assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (!bus.imem_req || bus.imem_ack)
            r_wait_cnt <= 0;
        else
            r_wait_cnt <= r_wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] ins);
        check({tag, "_valid"}, {31'd0, bus.valid}, {31'd0, v});
        check({tag, "_pc"},    bus.PC, pc);
        check({tag, "_instr"}, bus.instruction, ins);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total          = 0;
        n_bad            = 0;
        r_wait_cnt       = 0;
        mem_lat          = 0;
        rst              = 1'b1;
        bus.freeze       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr  = 32'd0;
        tick();
        tick();
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        check_out("rst", 1'b0, 32'd0, 32'd0);

        // 1: zero-wait streaming
        rst = 1'b0;
        #1;
        check("t1_req_low", {31'd0, bus.imem_req}, 32'd0);
        tick();
        check("t1_req_high", {31'd0, bus.imem_req}, 32'd1);
        check("t1_empty", {31'd0, bus.valid}, 32'd0);
        tick();
        check_out("t1_w0", 1'b1, 32'd4, 32'hA5A5_0000);
        tick();
        check_out("t1_w1", 1'b1, 32'd8, 32'hA5A5_0004);
        tick();
        check_out("t1_w2", 1'b1, 32'd12, 32'hA5A5_0008);

        // 2: freeze with a full buffer
        bus.freeze = 1'b1;
        #1;
        check("t2_req_off", {31'd0, bus.imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("t2_hold", 1'b1, 32'd12, 32'hA5A5_0008);
            check("t2_req_hold", {31'd0, bus.imem_req}, 32'd0);
        end
        bus.freeze = 1'b0;
        tick();
        check_out("t2_resume", 1'b1, 32'd16, 32'hA5A5_000C);

        // 3: three-cycle memory latency
        mem_lat = 3;
        #1;
        check("t3_addr0", bus.imem_addr, 32'h10);
        check("t3_ack0", {31'd0, bus.imem_ack}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_addr_wait", bus.imem_addr, 32'h10);
            check_out("t3_gap", 1'b0, 32'd0, 32'd0);
        end
        tick();
        check_out("t3_word", 1'b1, 32'h14, 32'hA5A5_0010);

        // 4: branch in the same cycle as an ack
        mem_lat          = 0;
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h10;
        tick();
        bus.branch_taken = 1'b0;
        #1;
        check("t4_addr_pre", bus.imem_addr, 32'h10);
        check("t4_ack_pre", {31'd0, bus.imem_ack}, 32'd1);
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h100;
        tick();
        bus.branch_taken = 1'b0;
        #1;
        check_out("t4_drop", 1'b0, 32'd0, 32'd0);
        check("t4_addr", bus.imem_addr, 32'h100);
        tick();
        check_out("t4_word", 1'b1, 32'h104, 32'hA5A5_0100);

        // 5: branch while a fetch awaits its ack
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h20;
        tick();
        bus.branch_taken = 1'b0;
        mem_lat          = 2;
        #1;
        check("t5_addr0", bus.imem_addr, 32'h20);
        check("t5_ack0", {31'd0, bus.imem_ack}, 32'd0);
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h200;
        tick();
        bus.branch_taken = 1'b0;
        #1;
        check("t5_sq_addr1", bus.imem_addr, 32'h20);
        check("t5_sq_req1", {31'd0, bus.imem_req}, 32'd1);
        check("t5_sq_valid1", {31'd0, bus.valid}, 32'd0);
        tick();
        check("t5_sq_addr2", bus.imem_addr, 32'h20);
        check("t5_sq_ack", {31'd0, bus.imem_ack}, 32'd1);
        tick();
        check("t5_new_addr", bus.imem_addr, 32'h200);
        check_out("t5_dropped", 1'b0, 32'd0, 32'd0);
        mem_lat = 0;
        tick();
        check_out("t5_word", 1'b1, 32'h204, 32'hA5A5_0200);

        // PC wraps modulo 2^32
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'hFFFF_FFFC;
        tick();
        bus.branch_taken = 1'b0;
        #1;
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        check_out("wrap", 1'b1, 32'd0, 32'h5A5A_FFFC);
        check("wrap_next_addr", bus.imem_addr, 32'd0);

        // 6: reset in the middle of a wait
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h40;
        tick();
        bus.branch_taken = 1'b0;
        mem_lat          = 5;
        #1;
        check("t6_wait_addr", bus.imem_addr, 32'h40);
        tick();
        rst = 1'b1;
        #1;
        check("t6_req", {31'd0, bus.imem_req}, 32'd0);
        check("t6_addr", bus.imem_addr, 32'd0);
        check_out("t6_rst", 1'b0, 32'd0, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("t6_req_low", {31'd0, bus.imem_req}, 32'd0);
        tick();
        check("t6_first_addr", bus.imem_addr, 32'd0);
        check("t6_first_req", {31'd0, bus.imem_req}, 32'd1);
        mem_lat = 0;
        tick();
        check_out("t6_word", 1'b1, 32'd4, 32'hA5A5_0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
